// File: rtl/rv2t_data_access_unit_if.sv
// rtl/rv2t_data_access_unit_if.sv - request, memory-port and completion signals of the data access unit
interface rv2t_data_access_unit_if #(
  parameter int MEM_ADDR_BITS = 14,
  parameter int XLEN          = 32
);
  localparam int XLEN_BYTES = XLEN / 8;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [1:0]               req_width;
  logic                     req_unsigned;
  logic [31:0]              req_addr;
  logic [31:0]              req_wdata;
  logic [4:0]               req_rd;
  logic                     mem_busy;
  logic                     data_read_enable;
  logic [XLEN_BYTES-1:0]    data_write_enable;
  logic [MEM_ADDR_BITS-1:0] data_rw_addr;
  logic [XLEN-1:0]          data_write_word;
  logic                     mem_enable_in;
  logic [XLEN-1:0]          mem_word_in;
  logic                     load_valid;
  logic [31:0]              load_data;
  logic [4:0]               load_rd;
  logic                     store_done;
  logic                     exc_misaligned;
  logic [31:0]              exc_addr;

  modport slave (
    input  req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, req_rd,
    input  mem_busy, mem_enable_in, mem_word_in,
    output req_ready, data_read_enable, data_write_enable, data_rw_addr, data_write_word,
    output load_valid, load_data, load_rd, store_done, exc_misaligned, exc_addr
  );

  modport master (
    output req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, req_rd,
    output mem_busy, mem_enable_in, mem_word_in,
    input  req_ready, data_read_enable, data_write_enable, data_rw_addr, data_write_word,
    input  load_valid, load_data, load_rd, store_done, exc_misaligned, exc_addr
  );
endinterface

// File: rtl/rv2t_data_access_unit.sv
// rtl/rv2t_data_access_unit.sv - single-outstanding load/store sequencer in front of the memory stage
module rv2t_data_access_unit #(
  parameter int MEM_ADDR_BITS = 14,
  parameter int XLEN          = 32
) (
  input logic                   clk,
  input logic                   sync_reset,
  rv2t_data_access_unit_if.slave bus
);
  localparam int XLEN_BYTES = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                   state, state_next;
  logic                     r_write;
  logic [1:0]               r_width;
  logic                     r_unsigned;
  logic [MEM_ADDR_BITS+1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [4:0]               r_rd;

  logic                     accept, misaligned;
  logic                     read_en;
  logic [XLEN_BYTES-1:0]    write_en, lane_mask;
  logic [31:0]              write_word, load_ext;
  logic [7:0]               lane_b;
  logic [15:0]              lane_h;

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    case (bus.req_width)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Stores replicate the datum across lanes so the strobe mask alone selects the bytes.
  always_comb begin
    lane_mask  = 4'b1111;
    write_word = r_wdata;
    case (r_width)
      2'b00: begin
        lane_mask  = 4'b0001 << r_addr[1:0];
        write_word = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask  = 4'b0011 << {r_addr[1], 1'b0};
        write_word = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b   = 8'(bus.mem_word_in >> {r_addr[1:0], 3'b000});
    lane_h   = r_addr[1] ? bus.mem_word_in[31:16] : bus.mem_word_in[15:0];
    load_ext = bus.mem_word_in;
    case (r_width)
      2'b00:   load_ext = {{24{~r_unsigned & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~r_unsigned & lane_h[15]}}, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    read_en       = 1'b0;
    write_en      = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid && !misaligned) state_next = ISSUE;
      end
      ISSUE: begin
        if (!bus.mem_busy) begin
          if (r_write) begin
            write_en   = lane_mask;
            state_next = IDLE;
          end else begin
            read_en    = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_enable_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state              <= IDLE;
      r_write            <= 1'b0;
      r_width            <= 2'b00;
      r_unsigned         <= 1'b0;
      r_addr             <= '0;
      r_wdata            <= '0;
      r_rd               <= '0;
      bus.load_valid     <= 1'b0;
      bus.load_data      <= '0;
      bus.load_rd        <= '0;
      bus.store_done     <= 1'b0;
      bus.exc_misaligned <= 1'b0;
      bus.exc_addr       <= '0;
    end else begin
      state              <= state_next;
      bus.load_valid     <= 1'b0;
      bus.store_done     <= 1'b0;
      bus.exc_misaligned <= 1'b0;
      if (accept) begin
        if (misaligned) begin
          bus.exc_misaligned <= 1'b1;
          bus.exc_addr       <= bus.req_addr;
        end else begin
          r_write    <= bus.req_write;
          r_width    <= bus.req_width;
          r_unsigned <= bus.req_unsigned;
          r_addr     <= bus.req_addr[MEM_ADDR_BITS+1:0];
          r_wdata    <= bus.req_wdata;
          r_rd       <= bus.req_rd;
        end
      end
      if (state == ISSUE && !bus.mem_busy && r_write) bus.store_done <= 1'b1;
      if (state == WAIT && bus.mem_enable_in) begin
        bus.load_valid <= 1'b1;
        bus.load_data  <= load_ext;
        bus.load_rd    <= r_rd;
      end
    end
  end

  assign bus.data_read_enable  = read_en;
  assign bus.data_write_enable = write_en;
  assign bus.data_rw_addr      = r_addr[MEM_ADDR_BITS+1:2];
  assign bus.data_write_word   = write_word;
endmodule

// File: tb/tb_rv2t_data_access_unit.sv
// tb/tb_rv2t_data_access_unit.sv - scoreboard bench for the data access unit
module tb_rv2t_data_access_unit;
  logic clk = 1'b0;
  logic sync_reset;
  logic [31:0] mem_word;
  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] sb_load[$];
  logic [31:0] sb_exc[$];

  always #5 clk = ~clk;

  rv2t_data_access_unit_if #(.MEM_ADDR_BITS(14), .XLEN(32)) bus ();

  rv2t_data_access_unit #(.MEM_ADDR_BITS(14), .XLEN(32)) dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .bus(bus.slave)
  );

  // Memory stage stand-in: read data and its valid arrive one cycle after the read enable.
  always @(posedge clk) begin
    bus.mem_enable_in <= bus.data_read_enable & ~sync_reset;
    bus.mem_word_in   <= mem_word;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (bus.load_valid === 1'b1) begin
      if (sb_load.size() == 0) check("spurious_load_valid", 32'd1, 32'd0);
      else begin
        logic [36:0] e;
        e = sb_load.pop_front();
        check("load_data", bus.load_data, e[31:0]);
        check("load_rd", 32'(bus.load_rd), 32'(e[36:32]));
      end
    end
    if (bus.exc_misaligned === 1'b1) begin
      if (sb_exc.size() == 0) check("spurious_exc", 32'd1, 32'd0);
      else check("exc_addr", bus.exc_addr, sb_exc.pop_front());
    end
    if (bus.data_read_enable === 1'b1 && bus.data_write_enable !== 4'b0000)
      check("strobe_exclusive", 32'(bus.data_write_enable), 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] width, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_write    = wr;
    bus.req_width    = width;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
  endtask

  task automatic wait_load();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.load_valid === 1'b1) seen = 1;
    end
    if (!seen) check("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] width, input logic uns,
                         input logic [4:0] rd, input logic [31:0] word, input logic [31:0] exp);
    mem_word = word;
    sb_load.push_back({rd, exp});
    drive_req(1'b0, width, uns, addr, 32'd0, rd);
    step();
    bus.req_valid = 1'b0;
    wait_load();
    step();
  endtask

  initial begin
    sync_reset    = 1'b1;
    mem_word      = '0;
    bus.mem_busy  = 1'b0;
    drive_req(1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0);
    bus.req_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_load_valid", 32'(bus.load_valid), 32'd0);
    check("rst_rw_addr", 32'(bus.data_rw_addr), 32'd0);
    check("rst_write_word", bus.data_write_word, 32'd0);
    step();
    sync_reset = 1'b0;

    // Load word at 0x100 with exact cycle timing.
    mem_word = 32'hDEADBEEF;
    sb_load.push_back({5'd7, 32'hDEADBEEF});
    drive_req(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5'd7);
    @(negedge clk);
    check("t1_ready", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("t1_rd_en_n1", 32'(bus.data_read_enable), 32'd1);
    check("t1_rw_addr", 32'(bus.data_rw_addr), 32'h40);
    check("t1_wr_en_n1", 32'(bus.data_write_enable), 32'd0);
    check("t1_busy_ready", 32'(bus.req_ready), 32'd0);
    step();
    @(negedge clk);
    check("t1_lv_n2", 32'(bus.load_valid), 32'd0);
    step();
    @(negedge clk);
    check("t1_lv_n3", 32'(bus.load_valid), 32'd1);
    step();

    // Extension cases from one memory word.
    do_load(32'h103, 2'b00, 1'b0, 5'd3, 32'h80FF7F01, 32'hFFFFFF80);
    do_load(32'h102, 2'b00, 1'b1, 5'd4, 32'h80FF7F01, 32'h000000FF);
    do_load(32'h102, 2'b01, 1'b0, 5'd5, 32'h80FF7F01, 32'hFFFF80FF);
    do_load(32'h100, 2'b01, 1'b1, 5'd6, 32'h80FF7F01, 32'h00007F01);
    do_load(32'h101, 2'b00, 1'b0, 5'd8, 32'h80FF7F01, 32'h0000007F);

    // Half store at 0x202.
    drive_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd0);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("st_mask", 32'(bus.data_write_enable), 32'hC);
    check("st_word", bus.data_write_word, 32'hABCDABCD);
    check("st_rd_en", 32'(bus.data_read_enable), 32'd0);
    check("st_rw_addr", 32'(bus.data_rw_addr), 32'h80);
    check("st_done_n1", 32'(bus.store_done), 32'd0);
    step();
    @(negedge clk);
    check("st_done_n2", 32'(bus.store_done), 32'd1);
    step();

    // Misaligned half store at 0x201.
    sb_exc.push_back(32'h201);
    drive_req(1'b1, 2'b01, 1'b0, 32'h201, 32'h1234ABCD, 5'd0);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis_no_strobe", 32'(bus.data_write_enable), 32'd0);
      check("mis_ready", 32'(bus.req_ready), 32'd1);
      check("mis_pulse", 32'(bus.exc_misaligned), (i == 0) ? 32'd1 : 32'd0);
      check("mis_no_done", 32'(bus.store_done), 32'd0);
      step();
    end

    // Reserved width traps as misaligned.
    sb_exc.push_back(32'h300);
    drive_req(1'b0, 2'b11, 1'b0, 32'h300, 32'd0, 5'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("w11_exc", 32'(bus.exc_misaligned), 32'd1);
    check("w11_no_rd", 32'(bus.data_read_enable), 32'd0);
    step();

    // Three busy cycles in ISSUE delay the read enable to N+4.
    mem_word = 32'h55AA1234;
    sb_load.push_back({5'd9, 32'h55AA1234});
    bus.mem_busy = 1'b1;
    drive_req(1'b0, 2'b10, 1'b0, 32'h400, 32'd0, 5'd9);
    step();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_no_rd", 32'(bus.data_read_enable), 32'd0);
      check("busy_no_wr", 32'(bus.data_write_enable), 32'd0);
      step();
    end
    bus.mem_busy = 1'b0;
    @(negedge clk);
    check("busy_rd_n4", 32'(bus.data_read_enable), 32'd1);
    step();
    @(negedge clk);
    check("busy_lv_n5", 32'(bus.load_valid), 32'd0);
    step();
    @(negedge clk);
    check("busy_lv_n6", 32'(bus.load_valid), 32'd1);
    step();

    // Store accepted in the load_valid cycle of the preceding load.
    mem_word = 32'h0BADF00D;
    sb_load.push_back({5'd11, 32'h0BADF00D});
    drive_req(1'b0, 2'b10, 1'b0, 32'h500, 32'd0, 5'd11);
    step();
    drive_req(1'b1, 2'b10, 1'b0, 32'h600, 32'hCAFEBABE, 5'd0);
    @(negedge clk);
    check("b2b_ready_n1", 32'(bus.req_ready), 32'd0);
    step();
    step();
    @(negedge clk);
    check("b2b_lv_n3", 32'(bus.load_valid), 32'd1);
    check("b2b_ready_n3", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_mask", 32'(bus.data_write_enable), 32'hF);
    check("b2b_word", bus.data_write_word, 32'hCAFEBABE);
    check("b2b_rw_addr", 32'(bus.data_rw_addr), 32'h180);
    step();
    @(negedge clk);
    check("b2b_done", 32'(bus.store_done), 32'd1);
    step();

    // Reset while waiting for read data discards the load.
    mem_word = 32'h12345678;
    drive_req(1'b0, 2'b10, 1'b0, 32'h700, 32'd0, 5'd13);
    step();
    bus.req_valid = 1'b0;
    step();
    sync_reset = 1'b1;
    @(negedge clk);
    check("wait_ready", 32'(bus.req_ready), 32'd0);
    step();
    sync_reset = 1'b0;
    @(negedge clk);
    check("mrst_ready", 32'(bus.req_ready), 32'd1);
    check("mrst_load_data", bus.load_data, 32'd0);
    check("mrst_load_rd", 32'(bus.load_rd), 32'd0);
    check("mrst_exc_addr", bus.exc_addr, 32'd0);
    check("mrst_rw_addr", 32'(bus.data_rw_addr), 32'd0);
    check("mrst_write_word", bus.data_write_word, 32'd0);
    check("mrst_rd_en", 32'(bus.data_read_enable), 32'd0);
    check("mrst_wr_en", 32'(bus.data_write_enable), 32'd0);
    check("mrst_pulses", {29'd0, bus.load_valid, bus.store_done, bus.exc_misaligned}, 32'd0);
    repeat (6) step();

    check("sb_load_empty", 32'(sb_load.size()), 32'd0);
    check("sb_exc_empty", 32'(sb_exc.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
